// File: rtl/rr_dist_buf_if.sv
// Handshake bundle between one producer, rr_dist_buf and its NumOut consumer lanes.
// The slave side is the distributor; the master side is the surrounding logic.
interface rr_dist_buf_if #(
  parameter int unsigned NumOut    = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdxWidth  = $clog2(NumOut),
  parameter int unsigned FillWidth = $clog2(NumOut + 1)
);
  logic [IdxWidth-1:0]         sel_i;
  logic                        valid_i;
  logic                        ready_o;
  logic [DataWidth-1:0]        data_i;
  logic [IdxWidth-1:0]         idx_o;
  logic                        drop_o;
  logic [NumOut-1:0]           valid_o;
  logic [NumOut-1:0]           ready_i;
  logic [NumOut*DataWidth-1:0] data_o;
  logic [FillWidth-1:0]        fill_o;

  modport master (
    output sel_i, valid_i, data_i, ready_i,
    input  ready_o, idx_o, drop_o, valid_o, data_o, fill_o
  );

  modport slave (
    input  sel_i, valid_i, data_i, ready_i,
    output ready_o, idx_o, drop_o, valid_o, data_o, fill_o
  );
endinterface

// File: rtl/rr_dist_buf.sv
// 1-to-NumOut stream distributor: round-robin (or externally selected) lane choice,
// one output register per lane, 1-cycle latency, full rate when the target lane is free.
module rr_dist_buf #(
  parameter int unsigned NumOut    = 4,
  parameter int unsigned DataWidth = 32,
  parameter bit          ExtSel    = 1'b0,
  parameter bit          FairDist  = 1'b1,
  parameter int unsigned IdxWidth  = $clog2(NumOut)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  rr_dist_buf_if.slave bus
);
  localparam int unsigned       FillWidth = $clog2(NumOut + 1);
  localparam logic [IdxWidth:0] NumOutW   = (IdxWidth + 1)'(NumOut);
  localparam logic [IdxWidth-1:0] LastLane = IdxWidth'(NumOut - 1);

  logic [NumOut-1:0]    valid_q;
  logic [DataWidth-1:0] data_q [NumOut];
  logic [IdxWidth-1:0]  rr_q;
  logic [IdxWidth-1:0]  rr_d;
  logic                 drop_q;

  logic [NumOut-1:0]    free;
  logic [NumOut-1:0]    free_rot;
  logic [NumOut-1:0]    load;
  logic [IdxWidth-1:0]  tgt;
  logic [IdxWidth-1:0]  off;
  logic [IdxWidth:0]    sum;
  logic                 any_free;
  logic                 tgt_ok;
  logic                 rdy;
  logic                 hs;
  logic [FillWidth-1:0] fill_d;

  // A lane can take a beat if it is empty or is being drained this cycle.
  assign free = ~valid_q | bus.ready_i;

  always_comb begin
    tgt      = rr_q;
    tgt_ok   = 1'b1;
    rdy      = 1'b0;
    free_rot = '0;
    off      = '0;
    any_free = 1'b0;
    sum      = '0;
    if (ExtSel) begin
      tgt    = bus.sel_i;
      tgt_ok = ({1'b0, bus.sel_i} < NumOutW);
      // Out-of-range selects match no lane and are accepted for discarding.
      rdy    = 1'b1;
      for (int unsigned k = 0; k < NumOut; k++) begin
        if (bus.sel_i == IdxWidth'(k)) rdy = free[k];
      end
    end else if (FairDist) begin
      // Rotate so bit 0 is the pointer lane; the lowest set bit is then the
      // first free lane at or after rr_q, and its offset is added back mod NumOut.
      free_rot = NumOut'({free, free} >> rr_q);
      for (int unsigned j = 0; j < NumOut; j++) begin
        if (!any_free && free_rot[j]) begin
          any_free = 1'b1;
          off      = IdxWidth'(j);
        end
      end
      sum = {1'b0, rr_q} + {1'b0, off};
      if (sum >= NumOutW) sum = sum - NumOutW;
      tgt = sum[IdxWidth-1:0];
      rdy = any_free;
    end else begin
      for (int unsigned k = 0; k < NumOut; k++) begin
        if (rr_q == IdxWidth'(k)) rdy = free[k];
      end
    end
  end

  assign hs = bus.valid_i & rdy;

  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < NumOut; k++) begin
      load[k] = hs & tgt_ok & (tgt == IdxWidth'(k));
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (!ExtSel && hs) begin
      rr_d = (tgt == LastLane) ? '0 : tgt + IdxWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      rr_q    <= '0;
      drop_q  <= 1'b0;
      for (int unsigned k = 0; k < NumOut; k++) data_q[k] <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
      rr_q    <= '0;
      drop_q  <= 1'b0;
      for (int unsigned k = 0; k < NumOut; k++) data_q[k] <= '0;
    end else begin
      rr_q   <= rr_d;
      drop_q <= hs & ~tgt_ok;
      for (int unsigned k = 0; k < NumOut; k++) begin
        // A load wins over a drain of the same lane, so there is no bubble.
        if (load[k]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= bus.data_i;
        end else if (bus.ready_i[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.data_o = '0;
    for (int unsigned k = 0; k < NumOut; k++) begin
      bus.data_o[k*DataWidth +: DataWidth] = data_q[k];
    end
  end

  always_comb begin
    fill_d = '0;
    for (int unsigned k = 0; k < NumOut; k++) begin
      fill_d = fill_d + FillWidth'(valid_q[k]);
    end
  end

  assign bus.ready_o = rdy;
  assign bus.idx_o   = tgt;
  assign bus.drop_o  = drop_q;
  assign bus.valid_o = valid_q;
  assign bus.fill_o  = fill_d;

  for (genvar k = 0; k < NumOut; k++) begin : g_hold
    hold_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
      (valid_q[k] && !bus.ready_i[k] && !flush_i) |=> $stable(data_q[k]));
  end

endmodule

// File: tb/tb_rr_dist_buf.sv
// Bench for rr_dist_buf: directed scenarios on three configurations, then randomized
// traffic checked against a lane/pointer reference model built from the selection rules.
module tb_rr_dist_buf;
  localparam int unsigned DW = 32;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;
  logic flush_c = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  rr_dist_buf_if #(.NumOut(4), .DataWidth(DW)) ifa ();
  rr_dist_buf_if #(.NumOut(4), .DataWidth(DW)) ifb ();
  rr_dist_buf_if #(.NumOut(3), .DataWidth(DW)) ifc ();

  rr_dist_buf #(.NumOut(4), .DataWidth(DW), .ExtSel(1'b0), .FairDist(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .bus(ifa.slave));
  rr_dist_buf #(.NumOut(4), .DataWidth(DW), .ExtSel(1'b0), .FairDist(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_b), .bus(ifb.slave));
  rr_dist_buf #(.NumOut(3), .DataWidth(DW), .ExtSel(1'b1), .FairDist(1'b0)) dut_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_c), .bus(ifc.slave));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Observed outputs of the selected DUT
  logic          o_ready, o_drop;
  logic [1:0]    o_idx;
  logic [3:0]    o_valid;
  logic [2:0]    o_fill;
  logic [DW-1:0] o_data [4];

  task automatic sample(input int d);
    for (int k = 0; k < 4; k++) o_data[k] = '0;
    case (d)
      0: begin
        o_ready = ifa.ready_o; o_drop = ifa.drop_o; o_idx = ifa.idx_o;
        o_valid = ifa.valid_o; o_fill = ifa.fill_o;
        for (int k = 0; k < 4; k++) o_data[k] = ifa.data_o[k*DW +: DW];
      end
      1: begin
        o_ready = ifb.ready_o; o_drop = ifb.drop_o; o_idx = ifb.idx_o;
        o_valid = ifb.valid_o; o_fill = ifb.fill_o;
        for (int k = 0; k < 4; k++) o_data[k] = ifb.data_o[k*DW +: DW];
      end
      default: begin
        o_ready = ifc.ready_o; o_drop = ifc.drop_o; o_idx = ifc.idx_o;
        o_valid = 4'(ifc.valid_o); o_fill = 3'(ifc.fill_o);
        for (int k = 0; k < 3; k++) o_data[k] = ifc.data_o[k*DW +: DW];
      end
    endcase
  endtask

  task automatic drive(input int d, input logic fl, input logic v, input logic [1:0] s,
                       input logic [DW-1:0] dat, input logic [3:0] r);
    case (d)
      0: begin flush_a = fl; ifa.valid_i = v; ifa.sel_i = s; ifa.data_i = dat; ifa.ready_i = r; end
      1: begin flush_b = fl; ifb.valid_i = v; ifb.sel_i = s; ifb.data_i = dat; ifb.ready_i = r; end
      default: begin
        flush_c = fl; ifc.valid_i = v; ifc.sel_i = s; ifc.data_i = dat; ifc.ready_i = r[2:0];
      end
    endcase
  endtask

  // Reference model: lane occupancy/payload, pointer and pending drop per DUT
  int unsigned   cfg_n    [3] = '{4, 4, 3};
  bit            cfg_ext  [3] = '{1'b0, 1'b0, 1'b1};
  bit            cfg_fair [3] = '{1'b1, 1'b0, 1'b0};
  bit            m_valid  [3][4];
  logic [DW-1:0] m_data   [3][4];
  int unsigned   m_rr     [3];
  bit            m_drop   [3];

  function automatic void m_clear(input int d);
    for (int k = 0; k < 4; k++) begin
      m_valid[d][k] = 1'b0;
      m_data[d][k]  = '0;
    end
    m_rr[d]   = 0;
    m_drop[d] = 1'b0;
  endfunction

  function automatic void m_select(input int d, input int unsigned sel, input logic [3:0] r,
                                   output bit rdy, output int unsigned tgt, output bit discard);
    bit fr [4];
    int unsigned n = cfg_n[d];
    for (int k = 0; k < 4; k++) fr[k] = (k < n) && (!m_valid[d][k] || r[k]);
    discard = 1'b0;
    rdy     = 1'b0;
    tgt     = m_rr[d];
    if (cfg_ext[d]) begin
      tgt = sel;
      if (sel >= n) begin
        rdy = 1'b1;
        discard = 1'b1;
      end else begin
        rdy = fr[sel];
      end
    end else if (cfg_fair[d]) begin
      for (int unsigned i = 0; i < n; i++) begin
        int unsigned lane = (m_rr[d] + i) % n;
        if (!rdy && fr[lane]) begin
          rdy = 1'b1;
          tgt = lane;
        end
      end
    end else begin
      rdy = fr[m_rr[d]];
    end
  endfunction

  function automatic void m_step(input int d, input logic fl, input logic v, input int unsigned sel,
                                 input logic [DW-1:0] dat, input logic [3:0] r);
    bit rdy, disc, hs;
    int unsigned tgt;
    if (fl) begin
      m_clear(d);
      return;
    end
    m_select(d, sel, r, rdy, tgt, disc);
    hs = v && rdy;
    m_drop[d] = hs && disc;
    for (int unsigned k = 0; k < cfg_n[d]; k++) begin
      if (hs && !disc && tgt == k) begin
        m_valid[d][k] = 1'b1;
        m_data[d][k]  = dat;
      end else if (r[k]) begin
        m_valid[d][k] = 1'b0;
      end
    end
    if (hs && !cfg_ext[d]) m_rr[d] = (tgt + 1) % cfg_n[d];
  endfunction

  task automatic test_reset();
    @(negedge clk);
    #1;
    sample(0);
    n_cmp++; if (o_valid !== 4'h0) begin n_bad++; $display("FAIL rst_valid got=%b exp=%b", o_valid, 4'h0); end
    n_cmp++; if (o_fill !== 3'd0) begin n_bad++; $display("FAIL rst_fill got=%0d exp=0", o_fill); end
    n_cmp++; if (o_drop !== 1'b0) begin n_bad++; $display("FAIL rst_drop got=%b exp=0", o_drop); end
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b exp=1", o_ready); end
    n_cmp++; if (o_idx !== 2'd0) begin n_bad++; $display("FAIL rst_idx got=%0d exp=0", o_idx); end
    n_cmp++;
    if ((o_data[0] | o_data[1] | o_data[2] | o_data[3]) !== 32'h0) begin
      n_bad++; $display("FAIL rst_data got=%h/%h/%h/%h exp=0", o_data[0], o_data[1], o_data[2], o_data[3]);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]    ev;
    logic [DW-1:0] ed;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        sample(0);
        ev = 4'(1 << ((i - 1) % 4));
        ed = 32'h10 + 32'(i - 1);
        n_cmp++; if (o_valid !== ev) begin n_bad++; $display("FAIL b2b_valid beat %0d got=%b exp=%b", i - 1, o_valid, ev); end
        n_cmp++; if (o_data[(i - 1) % 4] !== ed) begin n_bad++; $display("FAIL b2b_data beat %0d got=%h exp=%h", i - 1, o_data[(i - 1) % 4], ed); end
        n_cmp++; if (o_fill !== 3'd1) begin n_bad++; $display("FAIL b2b_fill beat %0d got=%0d exp=1", i - 1, o_fill); end
      end
      if (i < 8) drive(0, 1'b0, 1'b1, 2'd0, 32'h10 + 32'(i), 4'hF);
      else       drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
      #1;
      sample(0);
      if (i < 8) begin
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready beat %0d got=%b exp=1", i, o_ready); end
        n_cmp++; if (o_idx !== 2'(i % 4)) begin n_bad++; $display("FAIL b2b_idx beat %0d got=%0d exp=%0d", i, o_idx, i % 4); end
      end
    end
    @(negedge clk);
    sample(0);
    n_cmp++; if (o_valid !== 4'h0) begin n_bad++; $display("FAIL b2b_drain got=%b exp=0000", o_valid); end
  endtask

  task automatic test_fair_stall();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 2'd0, 32'h20 + 32'(i), 4'h0);
      #1; sample(0);
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL fair_ready beat %0d got=%b exp=1", i, o_ready); end
      n_cmp++; if (o_idx !== 2'(i)) begin n_bad++; $display("FAIL fair_idx beat %0d got=%0d exp=%0d", i, o_idx, i); end
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 2'd0, 32'h24, 4'h0);
    #1; sample(0);
    n_cmp++; if (o_valid !== 4'hF) begin n_bad++; $display("FAIL fair_full_valid got=%b exp=1111", o_valid); end
    n_cmp++; if (o_fill !== 3'd4) begin n_bad++; $display("FAIL fair_full_fill got=%0d exp=4", o_fill); end
    n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL fair_stall_ready got=%b exp=0", o_ready); end
    n_cmp++; if (o_idx !== 2'd0) begin n_bad++; $display("FAIL fair_stall_idx got=%0d exp=0", o_idx); end
    @(negedge clk);
    #1; sample(0);
    n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL fair_stall_hold got=%b exp=0", o_ready); end
    n_cmp++; if (o_data[1] !== 32'h21) begin n_bad++; $display("FAIL fair_hold_data got=%h exp=21", o_data[1]); end
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 2'd0, 32'h24, 4'b0100);
    #1; sample(0);
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL fair_free2_ready got=%b exp=1", o_ready); end
    n_cmp++; if (o_idx !== 2'd2) begin n_bad++; $display("FAIL fair_free2_idx got=%0d exp=2", o_idx); end
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 2'd0, 32'h25, 4'b1001);
    #1; sample(0);
    n_cmp++; if (o_valid !== 4'hF) begin n_bad++; $display("FAIL fair_reload_valid got=%b exp=1111", o_valid); end
    n_cmp++; if (o_data[2] !== 32'h24) begin n_bad++; $display("FAIL fair_reload_data got=%h exp=24", o_data[2]); end
    n_cmp++; if (o_data[3] !== 32'h23) begin n_bad++; $display("FAIL fair_keep_data got=%h exp=23", o_data[3]); end
    n_cmp++; if (o_idx !== 2'd3) begin n_bad++; $display("FAIL fair_ptr3_idx got=%0d exp=3", o_idx); end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
    #1; sample(0);
    n_cmp++; if (o_valid !== 4'b1110) begin n_bad++; $display("FAIL fair_after_valid got=%b exp=1110", o_valid); end
    n_cmp++; if (o_data[3] !== 32'h25) begin n_bad++; $display("FAIL fair_after_data got=%h exp=25", o_data[3]); end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  task automatic test_strict();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, 1'b0, 1'b1, 2'd0, 32'h30 + 32'(i), 4'b1101);
      #1; sample(1);
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL strict_ready beat %0d got=%b exp=1", i, o_ready); end
      n_cmp++; if (o_idx !== 2'(i % 4)) begin n_bad++; $display("FAIL strict_idx beat %0d got=%0d exp=%0d", i, o_idx, i % 4); end
    end
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'b1101);
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 2'd0, 32'h35, 4'h0);
    #1; sample(1);
    n_cmp++; if (o_valid !== 4'b0010) begin n_bad++; $display("FAIL strict_lane1_valid got=%b exp=0010", o_valid); end
    n_cmp++; if (o_data[1] !== 32'h31) begin n_bad++; $display("FAIL strict_lane1_data got=%h exp=31", o_data[1]); end
    n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL strict_stall_ready got=%b exp=0", o_ready); end
    n_cmp++; if (o_idx !== 2'd1) begin n_bad++; $display("FAIL strict_stall_idx got=%0d exp=1", o_idx); end
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 2'd0, 32'h35, 4'b0010);
    #1; sample(1);
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL strict_release_ready got=%b exp=1", o_ready); end
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 2'd0, 32'h36, 4'h0);
    #1; sample(1);
    n_cmp++; if (o_data[1] !== 32'h35) begin n_bad++; $display("FAIL strict_reload_data got=%h exp=35", o_data[1]); end
    n_cmp++; if (o_idx !== 2'd2) begin n_bad++; $display("FAIL strict_ptr2_idx got=%0d exp=2", o_idx); end
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
    #1; sample(1);
    n_cmp++; if (o_valid !== 4'b0110) begin n_bad++; $display("FAIL strict_final_valid got=%b exp=0110", o_valid); end
    n_cmp++; if (o_data[2] !== 32'h36) begin n_bad++; $display("FAIL strict_final_data got=%h exp=36", o_data[2]); end
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  task automatic test_ext_drop();
    @(negedge clk);
    drive(2, 1'b0, 1'b1, 2'd3, 32'hAA, 4'h0);
    #1; sample(2);
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL ext_oor_ready got=%b exp=1", o_ready); end
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    #1; sample(2);
    n_cmp++; if (o_drop !== 1'b1) begin n_bad++; $display("FAIL ext_drop_pulse got=%b exp=1", o_drop); end
    n_cmp++; if (o_valid !== 4'h0) begin n_bad++; $display("FAIL ext_drop_valid got=%b exp=000", o_valid); end
    @(negedge clk);
    drive(2, 1'b0, 1'b1, 2'd2, 32'hAA, 4'h0);
    #1; sample(2);
    n_cmp++; if (o_drop !== 1'b0) begin n_bad++; $display("FAIL ext_drop_end got=%b exp=0", o_drop); end
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL ext_sel2_ready got=%b exp=1", o_ready); end
    n_cmp++; if (o_idx !== 2'd2) begin n_bad++; $display("FAIL ext_sel2_idx got=%0d exp=2", o_idx); end
    @(negedge clk);
    drive(2, 1'b0, 1'b1, 2'd2, 32'hBB, 4'h0);
    #1; sample(2);
    n_cmp++; if (o_valid !== 4'b0100) begin n_bad++; $display("FAIL ext_lane2_valid got=%b exp=0100", o_valid); end
    n_cmp++; if (o_data[2] !== 32'hAA) begin n_bad++; $display("FAIL ext_lane2_data got=%h exp=aa", o_data[2]); end
    n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL ext_full_ready got=%b exp=0", o_ready); end
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
    #1; sample(2);
    n_cmp++; if (o_data[2] !== 32'hAA) begin n_bad++; $display("FAIL ext_no_overwrite got=%h exp=aa", o_data[2]); end
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 2'd0, 32'h40 + 32'(i), 4'h0);
      #1; sample(0);
      n_cmp++; if (o_idx !== 2'(i)) begin n_bad++; $display("FAIL flush_load_idx beat %0d got=%0d exp=%0d", i, o_idx, i); end
    end
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 2'd0, 32'h55, 4'h0);
    #1; sample(0);
    n_cmp++; if (o_fill !== 3'd3) begin n_bad++; $display("FAIL flush_pre_fill got=%0d exp=3", o_fill); end
    n_cmp++; if (o_idx !== 2'd3) begin n_bad++; $display("FAIL flush_pre_idx got=%0d exp=3", o_idx); end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    #1; sample(0);
    n_cmp++; if (o_valid !== 4'h0) begin n_bad++; $display("FAIL flush_valid got=%b exp=0000", o_valid); end
    n_cmp++; if (o_fill !== 3'd0) begin n_bad++; $display("FAIL flush_fill got=%0d exp=0", o_fill); end
    n_cmp++;
    if ((o_data[0] | o_data[1] | o_data[2] | o_data[3]) !== 32'h0) begin
      n_bad++; $display("FAIL flush_data got=%h/%h/%h/%h exp=0", o_data[0], o_data[1], o_data[2], o_data[3]);
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 2'd0, 32'h56, 4'h0);
    #1; sample(0);
    n_cmp++; if (o_idx !== 2'd0) begin n_bad++; $display("FAIL flush_ptr_idx got=%0d exp=0", o_idx); end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
    #1; sample(0);
    n_cmp++; if (o_valid !== 4'b0001) begin n_bad++; $display("FAIL flush_next_valid got=%b exp=0001", o_valid); end
    n_cmp++; if (o_data[0] !== 32'h56) begin n_bad++; $display("FAIL flush_next_data got=%h exp=56", o_data[0]); end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 2'd0, 32'h60 + 32'(i), 4'h0);
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    #1; sample(0);
    n_cmp++; if (o_fill !== 3'd2) begin n_bad++; $display("FAIL arst_pre_fill got=%0d exp=2", o_fill); end
    #2;
    rst = 1'b1;
    #1; sample(0);
    n_cmp++; if (o_valid !== 4'h0) begin n_bad++; $display("FAIL arst_valid got=%b exp=0000", o_valid); end
    n_cmp++; if (o_fill !== 3'd0) begin n_bad++; $display("FAIL arst_fill got=%0d exp=0", o_fill); end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 1'b1, 2'd0, 32'h70, 4'h0);
    #1; sample(0);
    n_cmp++; if (o_idx !== 2'd0) begin n_bad++; $display("FAIL arst_first_idx got=%0d exp=0", o_idx); end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
    #1; sample(0);
    n_cmp++; if (o_valid !== 4'b0001) begin n_bad++; $display("FAIL arst_first_valid got=%b exp=0001", o_valid); end
    n_cmp++; if (o_data[0] !== 32'h70) begin n_bad++; $display("FAIL arst_first_data got=%h exp=70", o_data[0]); end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  task automatic test_random(input int d, input int cycles);
    logic          fl, v;
    logic [1:0]    s;
    logic [DW-1:0] dat;
    logic [3:0]    r, ev;
    int unsigned   e_tgt, e_fill;
    bit            e_rdy, e_disc;
    @(negedge clk);
    drive(d, 1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
    m_clear(d);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      fl  = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 3) != 0);
      s   = 2'($urandom_range(0, 3));
      dat = $urandom;
      r   = (c < cycles / 2) ? 4'($urandom & $urandom) : 4'($urandom);
      drive(d, fl, v, s, dat, r);
      #1; sample(d);
      ev = '0;
      e_fill = 0;
      for (int unsigned k = 0; k < cfg_n[d]; k++) begin
        ev[k] = m_valid[d][k];
        e_fill += m_valid[d][k];
      end
      m_select(d, s, r, e_rdy, e_tgt, e_disc);
      n_cmp++; if (o_valid !== ev) begin n_bad++; $display("FAIL rnd%0d_valid cyc %0d got=%b exp=%b", d, c, o_valid, ev); end
      n_cmp++; if (o_fill !== 3'(e_fill)) begin n_bad++; $display("FAIL rnd%0d_fill cyc %0d got=%0d exp=%0d", d, c, o_fill, e_fill); end
      n_cmp++; if (o_drop !== m_drop[d]) begin n_bad++; $display("FAIL rnd%0d_drop cyc %0d got=%b exp=%b", d, c, o_drop, m_drop[d]); end
      n_cmp++; if (o_ready !== e_rdy) begin n_bad++; $display("FAIL rnd%0d_ready cyc %0d got=%b exp=%b", d, c, o_ready, e_rdy); end
      if (v) begin
        n_cmp++; if (o_idx !== 2'(e_tgt)) begin n_bad++; $display("FAIL rnd%0d_idx cyc %0d got=%0d exp=%0d", d, c, o_idx, e_tgt); end
      end
      for (int unsigned k = 0; k < cfg_n[d]; k++) begin
        n_cmp++;
        if (o_data[k] !== m_data[d][k]) begin
          n_bad++; $display("FAIL rnd%0d_data lane %0d cyc %0d got=%h exp=%h", d, k, c, o_data[k], m_data[d][k]);
        end
      end
      m_step(d, fl, v, 32'(s), dat, r);
    end
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    drive(2, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    test_reset();
    test_back_to_back();
    test_fair_stall();
    test_strict();
    test_ext_drop();
    test_flush();
    test_async_reset();
    test_random(0, 400);
    test_random(1, 400);
    test_random(2, 400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_dist_buf.md
Name: rr_dist_buf

Overview:
- 1-to-NumOut stream distributor with round-robin target selection and a one-entry output register per lane.
- It is the counterpart of the round-robin arbitration tree: it spreads one producer stream across N consumers, e.g. a request fan-out to parallel engines whose results are later merged by the arbiter.
- idx_o lets the upstream record the lane chosen for each beat so that responses can be reordered.

Parameters:
- NumOut, 4: number of output lanes, must be >= 2.
- DataWidth, 32: payload width in bits.
- ExtSel, 0: 1 = target lane is taken from sel_i; 0 = internal round-robin pointer.
- FairDist, 1: 1 = skip full lanes and pick the first free lane at or after the pointer; 0 = strict pointer order, stall while the pointed lane is full. Ignored when ExtSel=1.
- IdxWidth, $clog2(NumOut): derived, do not override.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  synchronous clear of all lane registers and the pointer.
- sel_i  in  IdxWidth  external lane select, used only when ExtSel=1.
- valid_i  in  1  input beat valid.
- ready_o  out  1  input beat accepted.
- data_i  in  DataWidth  input payload.
- idx_o  out  IdxWidth  lane chosen for the current input beat; meaningful only while valid_i=1.
- drop_o  out  1  one-cycle pulse when an accepted beat was discarded (sel_i out of range).
- valid_o  out  NumOut  per-lane output valid.
- ready_i  in  NumOut  per-lane output ready.
- data_o  out  NumOut*DataWidth  per-lane payload, packed; lane k occupies bits [k*DataWidth +: DataWidth].
- fill_o  out  $clog2(NumOut+1)  number of lanes whose register currently holds a beat.

Behaviour:

Reset and flush
- On rst_i: all valid_o=0, data_o=0, rr_q=0, drop_o=0, fill_o=0.
- ready_o and idx_o are combinational; with all lanes empty and rr_q=0, idx_o=0 and ready_o=valid_i-independent free status (1).
- flush_i=1: same state as reset on the next edge.
  - Any beat presented in that cycle is not stored, even if ready_o=1.
  - flush_i has priority over all other events.

Lane register k
- Free when valid_o[k]=0 or ready_i[k]=1 (draining this cycle).
- On input handshake (valid_i & ready_o) targeting k: next-cycle valid_o[k]=1, data_o[k]=data_i.
- Else if ready_i[k]=1: valid_o[k] clears.
- Simultaneous drain and load of the same lane: the new beat is loaded; no bubble.
- Output payload is held stable while valid_o[k]=1 and ready_i[k]=0.

Latency and throughput
- Input to output latency is exactly 1 cycle.
- Sustained rate is 1 beat per cycle whenever the target lane is free.

Target selection
- ExtSel=1:
  - target = sel_i.
  - If sel_i >= NumOut: ready_o=1, the beat is discarded, drop_o=1 the next cycle.
  - Otherwise ready_o = free[sel_i].
  - rr_q is unused.
- ExtSel=0, FairDist=0:
  - target = rr_q; ready_o = free[rr_q].
- ExtSel=0, FairDist=1:
  - Scan free[] from rr_q upward, wrapping past NumOut-1 to 0; target = first free lane.
  - ready_o = |free.
  - If no lane is free, ready_o=0 and idx_o=rr_q.
- Pointer update (internal modes): on handshake, rr_q <= target+1, wrapping NumOut-1 -> 0 (valid for non-power-of-2 NumOut). Without a handshake rr_q holds.

Handshake rules
- ready_o may depend on valid_o and ready_i.
- ready_o must not depend on valid_i.
- idx_o must not depend on valid_i or ready_o.
- The block never drops or duplicates a beat, except in the explicit drop_o case.

fill_o
- Equals popcount(valid_o) and reflects the registered state.

Reset mid-operation
- Asynchronous clear of all state regardless of pending handshakes.

Test Plan:
- NumOut=4, FairDist=1, all ready_i=1, 8 back-to-back beats 0x10..0x17 → lanes 0,1,2,3,0,1,2,3 with 1-cycle latency; ready_o constantly 1; fill_o steady at 1.
- FairDist=1, ready_i=4'b0000, 5 beats → beats 1-4 land in lanes 0-3, fill_o=4, the 5th stalls with ready_o=0. Then ready_i[2]=1 → the 5th beat loads lane 2 in the same cycle lane 2 drains; rr_q=3 afterwards.
- FairDist=0, lane 1 full and stalled, rr_q=1 → ready_o=0 even though lanes 0, 2 and 3 are free. Release ready_i[1] → beat goes to lane 1 and rr_q becomes 2.
- ExtSel=1, NumOut=3, sel_i=3, data 0xAA → ready_o=1, no valid_o rises, drop_o pulses 1 cycle. Then sel_i=2 → valid_o[2]=1, data_o[2]=0xAA.
- Lanes 0-2 hold data under backpressure, rr_q=3, flush_i=1 while valid_i=1 → next cycle valid_o=0, fill_o=0, rr_q=0, and the flush-cycle beat appears on no lane.
- rst_i asserted asynchronously between edges while lanes are full → valid_o and fill_o drop to 0 immediately; after release, the first beat goes to lane 0.
